// File: rtl/pe_sched_pkg.sv
// Shared constants and state encoding for the PE feed scheduler.
// Imported by the interface, the lane sub-module, the top and the bench.
package pe_sched_pkg;

  localparam int unsigned DefRows   = 8;
  localparam int unsigned DefDataW  = 16;
  localparam int unsigned DefKLen   = 4;
  localparam int unsigned DefAddrW  = 5;
  localparam int unsigned DefDrainMax = 64;

  // Widths of the flattened per-lane buses at default sizing.
  localparam int unsigned DefDataBusW = DefRows * DefDataW;
  localparam int unsigned DefAddrBusW = DefRows * DefAddrW;

  typedef logic [1:0] state_t;

  localparam state_t StIdle  = 2'd0;
  localparam state_t StFeed  = 2'd1;
  localparam state_t StDrain = 2'd2;
  localparam state_t StDone  = 2'd3;

endpackage

// File: rtl/pe_feed_scheduler_if.sv
// Control, Q/K buffer and cluster-lane signals of the feed scheduler.
// master = scheduler side, slave = environment (buffers, cluster, host).
interface pe_feed_scheduler_if
  import pe_sched_pkg::*;
#(
  parameter int unsigned ROWS   = DefRows,
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW
);
  logic                     en;
  logic                     start;
  logic                     busy;
  logic                     job_done;
  logic                     err;
  logic [ROWS-1:0]          rd_en;
  logic [ROWS*ADDR_W-1:0]   rd_addr;
  logic [ROWS*DATA_W-1:0]   act_rdata;
  logic [ROWS*DATA_W-1:0]   wgt_rdata;
  logic [ROWS*DATA_W-1:0]   activations;
  logic [ROWS*DATA_W-1:0]   weights;
  logic [ROWS-1:0]          done;
  logic                     cluster_done;

  modport master (
    input  en, start, act_rdata, wgt_rdata, cluster_done,
    output busy, job_done, err, rd_en, rd_addr, activations, weights, done
  );

  modport slave (
    output en, start, act_rdata, wgt_rdata, cluster_done,
    input  busy, job_done, err, rd_en, rd_addr, activations, weights, done
  );
endinterface

// File: rtl/pe_lane_skew.sv
// One cluster lane: skewed read strobe/address, registered data-valid and
// the sticky per-row done flag.
module pe_lane_skew
  import pe_sched_pkg::*;
#(
  parameter int unsigned LANE   = 0,
  parameter int unsigned K_LEN  = DefKLen,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned T_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  state_t            state,
  input  logic [T_W-1:0]    t,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              valid,
  output logic              done
);
  int   k;
  logic in_feed;
  logic active;
  logic finish;
  logic valid_q;
  logic done_q;

  always_comb begin
    k       = int'(t) - int'(LANE);
    in_feed = (state == StFeed);
    active  = in_feed && (k >= 0) && (k < int'(K_LEN));
    // First bubble after the last element marks the row complete.
    finish  = in_feed && (k == int'(K_LEN));
    rd_en   = active && en;
    rd_addr = active ? ADDR_W'(int'(LANE * K_LEN) + k) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (en) begin
      valid_q <= active;
      if (finish) begin
        done_q <= 1'b1;
      end else if (state == StDone) begin
        done_q <= 1'b0;
      end
    end
  end

  assign valid = valid_q;
  assign done  = done_q;

endmodule

// File: rtl/pe_feed_scheduler.sv
// Sequences one score-tile job: skewed Q/K reads into the 8x8 PE cluster,
// then waits (bounded) for the cluster's final done.
module pe_feed_scheduler
  import pe_sched_pkg::*;
#(
  parameter int unsigned ROWS      = DefRows,
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned K_LEN     = DefKLen,
  parameter int unsigned ADDR_W    = DefAddrW,
  parameter int unsigned DRAIN_MAX = DefDrainMax
) (
  input  logic                  clk,
  input  logic                  rst,
  pe_feed_scheduler_if.master   bus
);
  localparam int unsigned T_W = $clog2(ROWS + K_LEN);
  localparam int unsigned C_W = $clog2(DRAIN_MAX + 1);
  localparam logic [T_W-1:0] TLast = T_W'(ROWS + K_LEN - 1);
  localparam logic [C_W-1:0] CLast = C_W'(DRAIN_MAX - 1);

  state_t          state_q, state_d;
  logic [T_W-1:0]  t_q, t_d;
  logic [C_W-1:0]  cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [ROWS-1:0] valid;

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StFeed;
          t_d     = '0;
          err_d   = 1'b0;
        end
      end
      StFeed: begin
        if (t_q == TLast) begin
          state_d = StDrain;
          cnt_d   = '0;
        end else begin
          t_d = t_q + T_W'(1);
        end
      end
      StDrain: begin
        if (bus.cluster_done) begin
          state_d = StDone;
        end else if (cnt_q == CLast) begin
          // DRAIN_MAX drain cycles elapsed with no cluster done.
          state_d = StDone;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + C_W'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      t_q     <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else if (bus.en) begin
      state_q <= state_d;
      t_q     <= t_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.busy     = (state_q != StIdle);
  assign bus.job_done = (state_q == StDone);
  assign bus.err      = err_q;

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    pe_lane_skew #(
      .LANE   (r),
      .K_LEN  (K_LEN),
      .ADDR_W (ADDR_W),
      .T_W    (T_W)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .en      (bus.en),
      .state   (state_q),
      .t       (t_q),
      .rd_en   (bus.rd_en[r]),
      .rd_addr (bus.rd_addr[r*ADDR_W +: ADDR_W]),
      .valid   (valid[r]),
      .done    (bus.done[r])
    );

    assign bus.activations[r*DATA_W +: DATA_W] =
        valid[r] ? bus.act_rdata[r*DATA_W +: DATA_W] : '0;
    assign bus.weights[r*DATA_W +: DATA_W] =
        valid[r] ? bus.wgt_rdata[r*DATA_W +: DATA_W] : '0;
  end

endmodule

// File: tb/tb_pe_feed_scheduler.sv
// Self-checking bench for pe_feed_scheduler: buffer model with 1-cycle read
// latency and a job-level reference model driven by randomized stimulus.
module tb_pe_feed_scheduler;
  import pe_sched_pkg::*;

  localparam int ROWS      = DefRows;
  localparam int DATA_W    = DefDataW;
  localparam int K_LEN     = DefKLen;
  localparam int ADDR_W    = DefAddrW;
  localparam int DRAIN_MAX = DefDrainMax;
  localparam int DEPTH     = ROWS * K_LEN;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;
  bit exp_err = 1'b0;

  logic [DATA_W-1:0]      act_mem [DEPTH];
  logic [DATA_W-1:0]      wgt_mem [DEPTH];
  logic [DefDataBusW-1:0] act_q = '0;
  logic [DefDataBusW-1:0] wgt_q = '0;

  pe_feed_scheduler_if #(.ROWS(ROWS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  pe_feed_scheduler #(
    .ROWS(ROWS), .DATA_W(DATA_W), .K_LEN(K_LEN), .ADDR_W(ADDR_W), .DRAIN_MAX(DRAIN_MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Synchronous-read Q/K buffers: output register updates only on a strobe.
  always @(posedge clk) begin
    for (int r = 0; r < ROWS; r++) begin
      if (bus.rd_en[r]) begin
        act_q[r*DATA_W +: DATA_W] <= act_mem[bus.rd_addr[r*ADDR_W +: ADDR_W]];
        wgt_q[r*DATA_W +: DATA_W] <= wgt_mem[bus.rd_addr[r*ADDR_W +: ADDR_W]];
      end
    end
  end
  assign bus.act_rdata = act_q;
  assign bus.wgt_rdata = wgt_q;

  task automatic fill_mem(input bit rnd);
    for (int a = 0; a < DEPTH; a++) begin
      act_mem[a] = rnd ? DATA_W'($urandom) : DATA_W'(a + 1);
      wgt_mem[a] = rnd ? DATA_W'($urandom) : DATA_W'(16'h100 + a);
    end
  endtask

  // e = enabled cycles since the start was accepted; lane r shows element
  // e-1-r, done[r] rises once e passes r+K_LEN.
  task automatic run_job(input string tag, input bit skip_start, input bit hold,
                         input int stall_at, input int stall_len, input int cd_at,
                         input int stall_pct);
    int e, guard, stalled, feed_end, drain_len, done_e, k;
    bit timeout;
    logic [ROWS-1:0]        x_rd_en, x_done;
    logic [ROWS*ADDR_W-1:0] x_addr;
    logic [ROWS*DATA_W-1:0] x_act, x_wgt;
    feed_end  = ROWS + K_LEN;
    timeout   = (cd_at < 0) || (cd_at >= DRAIN_MAX);
    drain_len = timeout ? DRAIN_MAX : cd_at + 1;
    done_e    = feed_end + drain_len;
    if (!skip_start) begin
      bus.start = 1'b1; bus.en = 1'b1; bus.cluster_done = 1'b0;
      #4;
      n_cmp++;
      if (bus.busy !== 1'b0 || bus.err !== exp_err) begin
        n_bad++;
        $display("FAIL %s idle: busy=%b err=%b want busy=0 err=%b", tag, bus.busy, bus.err,
                 exp_err);
      end
      @(posedge clk); #1;
    end
    e = 0; guard = 0; stalled = 0;
    while (e <= done_e && guard < 2000) begin
      guard++;
      if (e == stall_at && stalled < stall_len) begin
        bus.en = 1'b0;
        stalled++;
      end else begin
        bus.en = ($urandom_range(99) >= stall_pct);
      end
      bus.start = hold ? 1'b1 : 1'($urandom_range(1));
      bus.cluster_done = (e < feed_end) ? 1'($urandom_range(1)) : (e - feed_end == cd_at);
      x_rd_en = '0; x_addr = '0; x_act = '0; x_wgt = '0; x_done = '0;
      for (int r = 0; r < ROWS; r++) begin
        k = e - r;
        if (e < feed_end && k >= 0 && k < K_LEN) begin
          x_rd_en[r] = bus.en;
          x_addr[r*ADDR_W +: ADDR_W] = ADDR_W'(r * K_LEN + k);
        end
        k = e - 1 - r;
        if (k >= 0 && k < K_LEN) begin
          x_act[r*DATA_W +: DATA_W] = act_mem[r*K_LEN + k];
          x_wgt[r*DATA_W +: DATA_W] = wgt_mem[r*K_LEN + k];
        end
        x_done[r] = (e >= r + K_LEN + 1);
      end
      #4;
      n_cmp++;
      if (bus.busy !== 1'b1 || bus.job_done !== (e == done_e)
          || bus.err !== (timeout && e == done_e)) begin
        n_bad++;
        $display("FAIL %s ctrl e=%0d: busy=%b job_done=%b err=%b want 1 %b %b", tag, e,
                 bus.busy, bus.job_done, bus.err, e == done_e, timeout && e == done_e);
      end
      n_cmp++;
      if (bus.rd_en !== x_rd_en || bus.rd_addr !== x_addr) begin
        n_bad++;
        $display("FAIL %s rd e=%0d: rd_en=%h rd_addr=%h want %h %h", tag, e, bus.rd_en,
                 bus.rd_addr, x_rd_en, x_addr);
      end
      n_cmp++;
      if (bus.activations !== x_act || bus.weights !== x_wgt) begin
        n_bad++;
        $display("FAIL %s lanes e=%0d: act=%h wgt=%h want %h %h", tag, e, bus.activations,
                 bus.weights, x_act, x_wgt);
      end
      n_cmp++;
      if (bus.done !== x_done) begin
        n_bad++;
        $display("FAIL %s done e=%0d: got %h want %h", tag, e, bus.done, x_done);
      end
      if (bus.en) e++;
      @(posedge clk); #1;
    end
    if (guard >= 2000) begin
      n_bad++;
      $display("FAIL %s bound: job still running after %0d cycles, want end", tag, guard);
    end
    bus.start = hold; bus.en = 1'b1; bus.cluster_done = 1'b0;
    exp_err = timeout;
    #4;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.job_done !== 1'b0 || bus.err !== exp_err
        || bus.done !== '0 || bus.rd_en !== '0 || bus.activations !== '0
        || bus.weights !== '0) begin
      n_bad++;
      $display("FAIL %s back_to_idle: busy=%b jd=%b err=%b done=%h rd_en=%h want 0 0 %b 0 0",
               tag, bus.busy, bus.job_done, bus.err, bus.done, bus.rd_en, exp_err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.en = 1'b0; bus.start = 1'b0; bus.cluster_done = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    #4;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.job_done !== 1'b0 || bus.err !== 1'b0 || bus.rd_en !== '0
        || bus.done !== '0 || bus.activations !== '0 || bus.weights !== '0) begin
      n_bad++;
      $display("FAIL reset: busy=%b jd=%b err=%b rd_en=%h done=%h act=%h want all 0",
               bus.busy, bus.job_done, bus.err, bus.rd_en, bus.done, bus.activations);
    end
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    #4;
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL start_while_stalled: busy=%b want 0", bus.busy);
    end
    @(posedge clk); #1;
    bus.en = 1'b1;
    exp_err = 1'b0;
  endtask

  task automatic test_basic();
    fill_mem(1'b0);
    run_job("basic", 1'b0, 1'b0, -1, 0, 3, 0);
  endtask

  task automatic test_timeout();
    run_job("timeout", 1'b0, 1'b0, -1, 0, -1, 0);
  endtask

  task automatic test_stall();
    run_job("stall", 1'b0, 1'b0, 5, 3, 1, 0);
  endtask

  task automatic test_mid_reset();
    bus.start = 1'b1; bus.en = 1'b1; bus.cluster_done = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #1; rst = 1'b1;
    #4;
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_reset_pre: busy=%b want 1", bus.busy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #4;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.job_done !== 1'b0 || bus.rd_en !== '0 || bus.done !== '0
        || bus.activations !== '0 || bus.weights !== '0) begin
      n_bad++;
      $display("FAIL mid_reset: busy=%b jd=%b rd_en=%h done=%h act=%h want all 0",
               bus.busy, bus.job_done, bus.rd_en, bus.done, bus.activations);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #5;
      n_cmp++;
      if (bus.busy !== 1'b0 || bus.job_done !== 1'b0) begin
        n_bad++;
        $display("FAIL mid_reset_quiet %0d: busy=%b jd=%b want 0 0", i, bus.busy,
                 bus.job_done);
      end
    end
    @(posedge clk); #1;
    exp_err = 1'b0;
    run_job("after_reset", 1'b0, 1'b0, -1, 0, 2, 0);
  endtask

  task automatic test_start_hold();
    run_job("hold_first", 1'b0, 1'b1, -1, 0, 2, 0);
    run_job("hold_second", 1'b1, 1'b0, -1, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int j = 0; j < 5; j++) begin
      fill_mem(1'b1);
      run_job("random", 1'b0, 1'b0, -1, 0,
              ($urandom_range(3) == 0) ? -1 : int'($urandom_range(6)), 25);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_stall();
    test_mid_reset();
    test_start_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
